udp_tx_framer: RTL and testbench

Transmit framer for the Ethernet/IPv4/UDP path. It takes a payload length and a byte stream of UDP data. It emits a complete GMII-style Ethernet frame on an 8-bit bus, one byte per clock: preamble/SFD, MAC header, IPv4 header with computed checksum, UDP header, payload, zero pad and CRC-32 FCS. Addresses and the port come from the `ProtocolInfo` package constants (`MAC_dest`, `MAC_src`, `IP_0..IP_2`, `IP_3src`, `IP_3des`, `UDP_Port`). The block sits between the payload source and the PHY transmit interface.

---
 rtl/udp_tx_framer.sv | 197 +++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: Ethernet/IPv4/UDP transmit framer, one GMII byte per clock.
// Builds preamble, headers with IP checksum, payload, pad and CRC-32 FCS.
package ProtocolInfo;
    localparam logic [47:0] MAC_dest = 48'h28D2_444F_D6AC;
    localparam logic [47:0] MAC_src  = 48'h000A_3501_0203;
    localparam logic [7:0]  IP_0     = 8'd192;
    localparam logic [7:0]  IP_1     = 8'd168;
    localparam logic [7:0]  IP_2     = 8'd1;
    localparam logic [7:0]  IP_3src  = 8'd20;
    localparam logic [7:0]  IP_3des  = 8'd25;
    localparam logic [15:0] UDP_Port = 16'h1F40;
endpackage

module udp_tx_framer
    import ProtocolInfo::*;
#(
    parameter int MAX_LEN = 1472,
    parameter int IFG     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] len,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        tx_er,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP
    } state_t;

    state_t      r_state, w_state_nx;
    logic [10:0] r_cnt, w_cnt_nx;
    logic [10:0] r_len;
    logic [15:0] r_csum;
    logic [31:0] r_crc;
    logic        r_len_err;

    logic        w_len_ok, w_short, w_crc_en;
    logic [31:0] w_acc, w_f1;
    logic [15:0] w_f2, w_csum;
    logic [15:0] w_ip_len, w_udp_len;
    logic [335:0] w_hdr;
    logic [8:0]  w_hdr_sh;
    logic [7:0]  w_byte;

    function automatic logic [31:0] crc8(input logic [31:0] c,
                                         input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        return x;
    endfunction

    assign w_len_ok = (int'(len) <= MAX_LEN);
    assign w_short  = (r_len < 11'd18);

    // Header checksum is derived from the incoming length so it is ready at once.
    assign w_acc = 32'h4500 + 32'(16'd28 + 16'(len)) + 32'h8011
                 + 32'({IP_0, IP_1}) + 32'({IP_2, IP_3src})
                 + 32'({IP_0, IP_1}) + 32'({IP_2, IP_3des});
    assign w_f1   = {16'h0, w_acc[31:16]} + {16'h0, w_acc[15:0]};
    assign w_f2   = w_f1[31:16] + w_f1[15:0];
    assign w_csum = ~w_f2;

    assign w_ip_len  = 16'd28 + 16'(r_len);
    assign w_udp_len = 16'd8 + 16'(r_len);
    assign w_hdr = {MAC_dest, MAC_src, 16'h0800,
                    8'h45, 8'h00, w_ip_len, 32'h0, 8'h80, 8'h11, r_csum,
                    IP_0, IP_1, IP_2, IP_3src, IP_0, IP_1, IP_2, IP_3des,
                    UDP_Port, UDP_Port, w_udp_len, 16'h0};
    assign w_hdr_sh = 9'd328 - {r_cnt[5:0], 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 11'd1;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (start && w_len_ok) w_state_nx = S_PRE;
            end
            S_PRE: if (r_cnt == 11'd6) begin
                w_state_nx = S_SFD;
                w_cnt_nx   = '0;
            end
            S_SFD: begin
                w_state_nx = S_HDR;
                w_cnt_nx   = '0;
            end
            S_HDR: if (r_cnt == 11'd41) begin
                w_state_nx = (r_len == 11'd0) ? S_PAD : S_PAY;
                w_cnt_nx   = '0;
            end
            S_PAY: if (r_cnt == r_len - 11'd1) begin
                w_state_nx = w_short ? S_PAD : S_FCS;
                w_cnt_nx   = '0;
            end
            S_PAD: if (r_cnt == 11'd17 - r_len) begin
                w_state_nx = S_FCS;
                w_cnt_nx   = '0;
            end
            S_FCS: if (r_cnt == 11'd3) begin
                w_state_nx = S_GAP;
                w_cnt_nx   = '0;
            end
            S_GAP: if (r_cnt == 11'(IFG - 1)) begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte    = 8'h00;
        tx_en     = 1'b0;
        tx_er     = 1'b0;
        pay_ready = 1'b0;
        done      = 1'b0;
        w_crc_en  = 1'b0;
        unique case (r_state)
            S_PRE: begin
                w_byte = 8'h55;
                tx_en  = 1'b1;
            end
            S_SFD: begin
                w_byte = 8'hD5;
                tx_en  = 1'b1;
            end
            S_HDR: begin
                w_byte   = 8'(w_hdr >> w_hdr_sh);
                tx_en    = 1'b1;
                w_crc_en = 1'b1;
            end
            S_PAY: begin
                w_byte    = pay_valid ? pay_data : 8'h00;
                tx_er     = ~pay_valid;
                tx_en     = 1'b1;
                pay_ready = 1'b1;
                w_crc_en  = 1'b1;
            end
            S_PAD: begin
                tx_en    = 1'b1;
                w_crc_en = 1'b1;
            end
            S_FCS: begin
                w_byte = 8'(~r_crc >> {r_cnt[1:0], 3'b000});
                tx_en  = 1'b1;
                done   = (r_cnt == 11'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_csum    <= '0;
            r_crc     <= 32'hFFFF_FFFF;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= (r_state == S_IDLE) && start && !w_len_ok;
            if (r_state == S_IDLE) begin
                r_crc <= 32'hFFFF_FFFF;
                if (start && w_len_ok) begin
                    r_len  <= len;
                    r_csum <= w_csum;
                end
            end else if (w_crc_en) begin
                r_crc <= crc8(r_crc, w_byte);
            end
        end
    end

    assign tx_data = w_byte;
    assign busy    = (r_state != S_IDLE);
    assign len_err = r_len_err;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Bench for udp_tx_framer: randomized payloads against a byte-level frame model.
// Directed cases cover field values, underrun, length limits and reset.
module tb_udp_tx_framer;
    localparam int MAX_LEN = 1472;
    localparam int IFG     = 12;
    localparam logic [47:0] T_MAC_D = 48'h28D2_444F_D6AC;
    localparam logic [47:0] T_MAC_S = 48'h000A_3501_0203;
    localparam logic [31:0] T_IP_S  = {8'd192, 8'd168, 8'd1, 8'd20};
    localparam logic [31:0] T_IP_D  = {8'd192, 8'd168, 8'd1, 8'd25};
    localparam logic [15:0] T_PORT  = 16'h1F40;

    logic clk = 1'b0;
    logic rst, start, pay_valid, pay_ready;
    logic [10:0] len;
    logic [7:0] pay_data, tx_data;
    logic tx_en, tx_er, busy, done, len_err;

    udp_tx_framer #(.MAX_LEN(MAX_LEN), .IFG(IFG)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
        .busy(busy), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    logic [7:0] pay_mem [0:2047];
    bit under [0:2047];
    int pidx = 0;
    int pbase = 0;
    int poff;
    assign poff = pidx - pbase;
    assign pay_valid = (poff >= 0 && poff < 2048) ? !under[poff] : 1'b0;
    assign pay_data  = pay_valid ? pay_mem[poff] : 8'hEE;
    always @(posedge clk) if (pay_ready) pidx <= pidx + 1;

    logic [7:0] cap_d[$];
    bit cap_e[$];
    int done_cnt = 0, done_at = 0, gap_cnt = 0, lerr_cnt = 0;
    always @(negedge clk) begin
        if (tx_en) begin
            cap_d.push_back(tx_data);
            cap_e.push_back(tx_er);
        end
        if (done) begin
            done_cnt++;
            done_at = cap_d.size();
        end
        if (busy && !tx_en) gap_cnt++;
        if (len_err) lerr_cnt++;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    logic [7:0] exp_d[$];
    bit exp_e[$];
    logic [7:0] lf[$];

    function automatic logic [15:0] ip_csum(input int n);
        logic [15:0] w [10];
        int s;
        w = '{16'h4500, 16'(28 + n), 16'h0, 16'h0, 16'h8011, 16'h0,
              T_IP_S[31:16], T_IP_S[15:0], T_IP_D[31:16], T_IP_D[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(w[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        return ~16'(s);
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        return x;
    endfunction

    task automatic push16(input logic [15:0] v);
        exp_d.push_back(v[15:8]);
        exp_d.push_back(v[7:0]);
    endtask

    task automatic build_exp(input int n);
        logic [31:0] crc;
        exp_d.delete();
        for (int i = 0; i < 7; i++) exp_d.push_back(8'h55);
        exp_d.push_back(8'hD5);
        for (int i = 0; i < 3; i++) push16(16'(T_MAC_D >> (32 - 16 * i)));
        for (int i = 0; i < 3; i++) push16(16'(T_MAC_S >> (32 - 16 * i)));
        push16(16'h0800); push16(16'h4500); push16(16'(28 + n));
        push16(16'h0); push16(16'h0); push16(16'h8011); push16(ip_csum(n));
        push16(T_IP_S[31:16]); push16(T_IP_S[15:0]);
        push16(T_IP_D[31:16]); push16(T_IP_D[15:0]);
        push16(T_PORT); push16(T_PORT); push16(16'(8 + n)); push16(16'h0);
        for (int i = 0; i < n; i++)
            exp_d.push_back(under[i] ? 8'h00 : pay_mem[i]);
        for (int i = n; i < 18; i++) exp_d.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_d.size(); i++) crc = crc_byte(crc, exp_d[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_d.push_back(8'(crc >> (8 * i)));
        exp_e.delete();
        for (int i = 0; i < exp_d.size(); i++)
            exp_e.push_back(i >= 50 && i < 50 + n && under[i - 50]);
    endtask

    task automatic run_frame(input int n, input bit poke);
        int base, g0, d0, l0, to, flen, mism;
        build_exp(n);
        @(negedge clk);
        pbase = pidx;
        base = cap_d.size(); g0 = gap_cnt; d0 = done_cnt; l0 = lerr_cnt;
        start = 1'b1;
        len = 11'(n);
        @(negedge clk);
        start = 1'b0;
        chk("first_en", 64'(tx_en), 64'(1));
        chk("first_55", 64'(tx_data), 64'h55);
        chk("busy_rise", 64'(busy), 64'(1));
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            len = 11'd2000;
            @(negedge clk);
            start = 1'b0;
        end
        to = 0;
        while (busy && to < 3000) begin
            @(negedge clk);
            to++;
        end
        chk("frame_timeout", 64'(busy), 64'(0));
        flen = cap_d.size() - base;
        chk("frame_len", 64'(flen), 64'(exp_d.size()));
        mism = 0;
        lf.delete();
        for (int i = 0; i < flen; i++) begin
            lf.push_back(cap_d[base + i]);
            if (i >= exp_d.size() || cap_d[base + i] !== exp_d[i]
                || cap_e[base + i] !== exp_e[i]) mism++;
        end
        chk("byte_mismatches", 64'(mism), 64'(0));
        chk("gap_cycles", 64'(gap_cnt - g0), 64'(IFG));
        chk("done_count", 64'(done_cnt - d0), 64'(1));
        chk("done_pos", 64'(done_at - base), 64'(exp_d.size()));
        chk("no_len_err", 64'(lerr_cnt - l0), 64'(0));
    endtask

    function automatic logic [15:0] f16(input int k);
        return {lf[k], lf[k + 1]};
    endfunction

    task automatic fill(input int n, input bit rnd, input int under_at);
        for (int i = 0; i < 2048; i++) begin
            pay_mem[i] = rnd ? 8'($urandom) : 8'(i);
            under[i] = 1'b0;
        end
        if (under_at >= 0) under[under_at] = 1'b1;
        if (rnd)
            for (int i = 0; i < n; i++) under[i] = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        fill(0, 1'b0, -1);
        repeat (3) @(negedge clk);
        chk("rst_tx_en", 64'(tx_en), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'h00);
        chk("rst_outs", 64'({tx_er, pay_ready, busy, done, len_err}), 64'(0));
        rst = 1'b0;

        fill(18, 1'b0, -1);
        run_frame(18, 1'b1);
        chk("n18_dmac", 64'({f16(8), f16(10), f16(12)}), 64'h28D2444FD6AC);
        chk("n18_totlen", 64'(f16(24)), 64'h002E);
        chk("n18_csum", 64'(f16(32)), 64'hB741);
        chk("n18_ports", 64'({f16(42), f16(44)}), 64'h1F401F40);
        chk("n18_udplen", 64'(f16(46)), 64'h001A);

        fill(1, 1'b0, -1);
        pay_mem[0] = 8'hA5;
        run_frame(1, 1'b0);
        chk("n1_totlen", 64'(f16(24)), 64'h001D);
        chk("n1_csum", 64'(f16(32)), 64'hB752);
        chk("n1_udplen", 64'(f16(46)), 64'h0009);
        chk("n1_payload", 64'(lf[50]), 64'hA5);

        fill(20, 1'b0, 5);
        run_frame(20, 1'b0);
        chk("ur_byte", 64'(lf[55]), 64'h00);
        chk("ur_flag", 64'(cap_e[cap_e.size() - 74 + 55]), 64'(1));

        fill(MAX_LEN, 1'b1, -1);
        run_frame(MAX_LEN, 1'b0);
        fill(0, 1'b0, -1);
        run_frame(0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        len = 11'd1473;
        @(negedge clk);
        start = 1'b0;
        chk("lerr_pulse", 64'(len_err), 64'(1));
        chk("lerr_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("lerr_once", 64'(len_err), 64'(0));
        chk("lerr_no_en", 64'({busy, tx_en}), 64'(0));

        for (int t = 0; t < 6; t++) begin
            int n;
            n = (t == 0) ? 17 : int'($urandom_range(0, 60));
            fill(n, 1'b1, -1);
            run_frame(n, t[0]);
        end

        fill(18, 1'b0, -1);
        @(negedge clk);
        pbase = pidx;
        start = 1'b1;
        len = 11'd18;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", 64'(tx_en), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_data", 64'(tx_data), 64'h00);
        rst = 1'b0;
        run_frame(18, 1'b0);
        chk("post_rst_csum", 64'(f16(32)), 64'hB741);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
